// File: rtl/csi2_packet_tx.sv
// csi2_packet_tx: 2-lane MIPI CSI-2 byte-level packet transmitter.
// One start sends FS, V_ACTIVE RAW8 test-pattern lines, then FE.
module csi2_packet_tx #(
  parameter int                    H_ACTIVE   = 640,
  parameter int                    V_ACTIVE   = 480,
  parameter int                    GAP        = 8,
  parameter logic [5:0]            DATA_TYPE  = 6'h2A,
  parameter logic [1:0]            VC         = 2'd0,
  parameter bit                    PAY_OVR_EN = 1'b0,
  parameter logic [8*H_ACTIVE-1:0] PAY_OVR    = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        hs_valid,
  output logic [7:0]  lane0_byte,
  output logic [7:0]  lane1_byte,
  output logic [15:0] frame_no,
  output logic [15:0] line_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR0, S_HDR1,
    S_PAY, S_CRC, S_GAP
  } state_t;

  typedef enum logic [1:0] {
    P_FS, P_LINE, P_FE
  } pkt_t;

  localparam logic [15:0] HA     = 16'(H_ACTIVE);
  localparam logic [15:0] VL     = 16'(V_ACTIVE - 1);
  localparam logic [15:0] GL     = 16'(GAP - 1);
  localparam logic [7:0]  SYNC_B = 8'hB8;

  state_t      state;
  pkt_t        pkt;
  logic [15:0] x;
  logic [15:0] gcnt;
  logic [15:0] crc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic [7:0]  di;
  logic [7:0]  ecc;
  logic [15:0] ovr_w;
  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [15:0] crc_nxt;

  function automatic logic [7:0] ecc_of(
    input logic [23:0] d
  );
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5]
         ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]
         ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6]
         ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
         ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8]
         ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
         ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8]
         ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14]
         ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[21] ^ d[22] ^ d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408), data LSB first.
  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    logic [7:0]  dd;
    r  = c;
    dd = d;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ dd[0])
        r = (r >> 1) ^ 16'h8408;
      else
        r = r >> 1;
      dd = dd >> 1;
    end
    return r;
  endfunction

  always_comb begin
    dt = DATA_TYPE;
    wc = HA;
    unique case (1'b1)
      pkt == P_FS: begin
        dt = 6'h00;
        wc = frame_no;
      end
      pkt == P_FE: begin
        dt = 6'h01;
        wc = frame_no;
      end
      default: ;
    endcase
    di  = {VC, dt};
    ecc = ecc_of({wc, di});
  end

  // x indexes the next byte pair to be emitted
  always_comb begin
    ovr_w = 16'(PAY_OVR >> {x, 3'b000});
    b0 = x[7:0] + line_cnt[7:0] + frame_no[7:0];
    b1 = b0 + 8'd1;
    if (PAY_OVR_EN) begin
      b0 = ovr_w[7:0];
      b1 = ovr_w[15:8];
    end
    crc_nxt = crc_byte(crc_byte(crc, b0), b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pkt        <= P_FS;
      x          <= '0;
      gcnt       <= '0;
      crc        <= 16'hFFFF;
      busy       <= 1'b0;
      hs_valid   <= 1'b0;
      lane0_byte <= '0;
      lane1_byte <= '0;
      frame_no   <= '0;
      line_cnt   <= '0;
    end else begin
      hs_valid   <= 1'b0;
      lane0_byte <= '0;
      lane1_byte <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            frame_no   <= frame_no + 16'd1;
            line_cnt   <= '0;
            pkt        <= P_FS;
            busy       <= 1'b1;
            state      <= S_SYNC;
            hs_valid   <= 1'b1;
            lane0_byte <= SYNC_B;
            lane1_byte <= SYNC_B;
          end
        end
        S_SYNC: begin
          state      <= S_HDR0;
          x          <= '0;
          hs_valid   <= 1'b1;
          lane0_byte <= di;
          lane1_byte <= wc[7:0];
        end
        S_HDR0: begin
          state      <= S_HDR1;
          crc        <= 16'hFFFF;
          hs_valid   <= 1'b1;
          lane0_byte <= wc[15:8];
          lane1_byte <= ecc;
        end
        S_HDR1: begin
          if (pkt == P_LINE) begin
            state      <= S_PAY;
            x          <= x + 16'd2;
            crc        <= crc_nxt;
            hs_valid   <= 1'b1;
            lane0_byte <= b0;
            lane1_byte <= b1;
          end else begin
            state <= S_GAP;
            gcnt  <= '0;
          end
        end
        S_PAY: begin
          hs_valid <= 1'b1;
          if (x == HA) begin
            state      <= S_CRC;
            lane0_byte <= crc[7:0];
            lane1_byte <= crc[15:8];
          end else begin
            x          <= x + 16'd2;
            crc        <= crc_nxt;
            lane0_byte <= b0;
            lane1_byte <= b1;
          end
        end
        S_CRC: begin
          state <= S_GAP;
          gcnt  <= '0;
        end
        S_GAP: begin
          if (gcnt == GL) begin
            if (pkt == P_FE) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= S_SYNC;
              hs_valid   <= 1'b1;
              lane0_byte <= SYNC_B;
              lane1_byte <= SYNC_B;
              if (pkt == P_FS) begin
                pkt      <= P_LINE;
                line_cnt <= '0;
              end else if (line_cnt == VL) begin
                pkt <= P_FE;
              end else begin
                line_cnt <= line_cnt + 16'd1;
              end
            end
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csi2_packet_tx.sv
// tb_csi2_packet_tx: directed checks of csi2_packet_tx framing,
// headers/ECC, payload pattern, CRC and reset/start corner cases.
module tb_csi2_packet_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [191:0] OVR =
    192'h010000FF_DF05F881_7CC275C8_5AB8D4BB_72F3DCB9_020000FF;

  localparam logic [5:0] COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15,
    6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32,
    6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  logic        d_rst, d_start, d_busy, d_v;
  logic [7:0]  d_l0, d_l1;
  logic [15:0] d_fn, d_ln;
  logic        s_rst, s_start, s_busy, s_v;
  logic [7:0]  s_l0, s_l1;
  logic [15:0] s_fn, s_ln;
  logic        c_rst, c_start, c_busy, c_v;
  logic [7:0]  c_l0, c_l1;
  logic [15:0] c_fn, c_ln;

  csi2_packet_tx u_def (
    .clk(clk), .reset(d_rst), .start(d_start),
    .busy(d_busy), .hs_valid(d_v),
    .lane0_byte(d_l0), .lane1_byte(d_l1),
    .frame_no(d_fn), .line_cnt(d_ln)
  );

  csi2_packet_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .GAP(3), .VC(2'd3)
  ) u_sml (
    .clk(clk), .reset(s_rst), .start(s_start),
    .busy(s_busy), .hs_valid(s_v),
    .lane0_byte(s_l0), .lane1_byte(s_l1),
    .frame_no(s_fn), .line_cnt(s_ln)
  );

  csi2_packet_tx #(
    .H_ACTIVE(24), .V_ACTIVE(1), .GAP(2),
    .PAY_OVR_EN(1'b1), .PAY_OVR(OVR)
  ) u_crc (
    .clk(clk), .reset(c_rst), .start(c_start),
    .busy(c_busy), .hs_valid(c_v),
    .lane0_byte(c_l0), .lane1_byte(c_l1),
    .frame_no(c_fn), .line_cnt(c_ln)
  );

  typedef struct {
    string      nm;
    int         cyc;
    logic       v;
    logic [7:0] l0;
    logic [7:0] l1;
  } vec_t;

  vec_t tv [12];

  int n_chk;
  int n_fail;

  localparam int NCAP = 1700;
  logic        rv [1:NCAP];
  logic        rb [1:NCAP];
  logic [7:0]  r0 [1:NCAP];
  logic [7:0]  r1 [1:NCAP];
  logic [15:0] rf [1:NCAP];
  logic [15:0] rl [1:NCAP];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_ecc(
    input logic [7:0]  di,
    input logic [15:0] wc
  );
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = '0;
    for (int i = 0; i < 24; i++)
      if (d[i]) e = e ^ COL[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] m_crc(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb    = c[0] ^ b[i];
      c     = {fb, c[15:1]};
      c[10] = c[10] ^ fb;
      c[3]  = c[3] ^ fb;
    end
    return c;
  endfunction

  task automatic pulse(input int w);
    @(negedge clk);
    case (w)
      0:       d_start = 1'b1;
      1:       s_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    d_start = 1'b0;
    s_start = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic capture(input int w, input int n,
                         input int p1, input int p2);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      case (w)
        0: begin
          rv[i] = d_v;  rb[i] = d_busy;
          r0[i] = d_l0; r1[i] = d_l1;
          rf[i] = d_fn; rl[i] = d_ln;
        end
        1: begin
          rv[i] = s_v;  rb[i] = s_busy;
          r0[i] = s_l0; r1[i] = s_l1;
          rf[i] = s_fn; rl[i] = s_ln;
        end
        default: begin
          rv[i] = c_v;  rb[i] = c_busy;
          r0[i] = c_l0; r1[i] = c_l1;
          rf[i] = c_fn; rl[i] = c_ln;
        end
      endcase
      s_start = (w == 1) && (i == p1 || i == p2);
    end
    s_start = 1'b0;
  endtask

  task automatic gaps(input string nm, input int n,
                      input int er, input int el);
    int runs = 0;
    int len  = 0;
    int bad  = 0;
    for (int i = 1; i <= n + 1; i++) begin
      if (i <= n && rb[i] && !rv[i]) begin
        len++;
      end else if (len != 0) begin
        runs++;
        if (len != el) bad++;
        len = 0;
      end
    end
    chk({nm, " gap runs"}, runs, er);
    chk({nm, " gap bad len"}, bad, 0);
  endtask

  function automatic int busy_cnt(input int n);
    int b = 0;
    for (int i = 1; i <= n; i++)
      if (rb[i]) b++;
    return b;
  endfunction

  initial begin
    logic [15:0]  c;
    logic [191:0] t;
    n_chk   = 0;
    n_fail  = 0;
    d_rst   = 1'b1;
    s_rst   = 1'b1;
    c_rst   = 1'b1;
    d_start = 1'b0;
    s_start = 1'b0;
    c_start = 1'b0;

    tv = '{
      '{"fs sync",     1,   1'b1, 8'hB8, 8'hB8},
      '{"fs hdr0",     2,   1'b1, 8'h00, 8'h01},
      '{"fs hdr1",     3,   1'b1, 8'h00, 8'h1A},
      '{"fs gap first",4,   1'b0, 8'h00, 8'h00},
      '{"fs gap last", 11,  1'b0, 8'h00, 8'h00},
      '{"l0 sync",     12,  1'b1, 8'hB8, 8'hB8},
      '{"l0 hdr0",     13,  1'b1, 8'h2A, 8'h80},
      '{"l0 hdr1",     14,  1'b1, 8'h02, 8'h0E},
      '{"l0 pay0",     15,  1'b1, 8'h01, 8'h02},
      '{"l0 pay1",     16,  1'b1, 8'h03, 8'h04},
      '{"l5 hdr1",     1674,1'b1, 8'h02, 8'h0E},
      '{"l5 pay0",     1675,1'b1, 8'h06, 8'h07}
    };

    #12;
    chk("rst busy", d_busy, 0);
    chk("rst valid", d_v, 0);
    chk("rst lane0", d_l0, 0);
    chk("rst lane1", d_l1, 0);
    chk("rst frame_no", d_fn, 0);
    chk("rst line_cnt", d_ln, 0);
    @(negedge clk);
    d_rst = 1'b0;
    s_rst = 1'b0;
    c_rst = 1'b0;

    // default-parameter frame, first 1700 cycles
    pulse(0);
    capture(0, NCAP, 0, 0);
    foreach (tv[i]) begin
      chk({tv[i].nm, " valid"}, rv[tv[i].cyc], tv[i].v);
      chk({tv[i].nm, " lane0"}, r0[tv[i].cyc], tv[i].l0);
      chk({tv[i].nm, " lane1"}, r1[tv[i].cyc], tv[i].l1);
    end
    chk("def frame_no", rf[1], 1);
    chk("def busy c1", rb[1], 1);
    chk("def fs ecc model", r1[3], m_ecc(8'h00, 16'h0001));
    chk("def line ecc model", r1[14],
        m_ecc(8'h2A, 16'h0280));
    chk("def line_cnt l0", rl[15], 0);
    chk("def line_cnt l5", rl[1675], 5);
    c = 16'hFFFF;
    for (int x = 0; x < 640; x++)
      c = m_crc(c, 8'(x + 1));
    chk("def l0 crc", {r1[335], r0[335]}, c);
    chk("def l0 crc valid", rv[335], 1);
    gaps("def", NCAP, 6, 8);

    // asynchronous reset in the middle of line 5 payload
    @(posedge clk);
    #2;
    chk("pre-rst valid in pay", d_v, 1);
    d_rst = 1'b1;
    #1;
    chk("mid rst valid", d_v, 0);
    chk("mid rst lane0", d_l0, 0);
    chk("mid rst lane1", d_l1, 0);
    chk("mid rst busy", d_busy, 0);
    chk("mid rst frame_no", d_fn, 0);
    @(negedge clk);
    d_rst = 1'b0;
    pulse(0);
    capture(0, 3, 0, 0);
    chk("restart sync", {r0[1], r1[1]}, 16'hB8B8);
    chk("restart fs hdr0", {r0[2], r1[2]}, 16'h0001);
    chk("restart fs hdr1", {r0[3], r1[3]}, 16'h001A);
    chk("restart frame_no", rf[1], 1);

    // small frame: VC=3, H=8, V=4, GAP=3
    // start pulsed mid-frame and on the final GAP cycle
    pulse(1);
    capture(1, 60, 20, 56);
    chk("sml busy cycles", busy_cnt(60), 56);
    chk("sml busy after", rb[57], 0);
    chk("sml frame_no end", rf[60], 1);
    chk("sml valid after", rv[58], 0);
    gaps("sml", 60, 6, 3);
    chk("sml fs hdr0", {r0[2], r1[2]}, 16'hC001);
    chk("sml fs ecc", r1[3], m_ecc(8'hC0, 16'h0001));
    chk("sml line hdr0", {r0[8], r1[8]}, 16'hEA08);
    chk("sml line wc hi", r0[9], 0);
    chk("sml line ecc", r1[9], m_ecc(8'hEA, 16'h0008));
    chk("sml fe hdr0", {r0[52], r1[52]}, 16'hC101);
    chk("sml fe wc hi", r0[53], 0);
    chk("sml fe ecc", r1[53], m_ecc(8'hC1, 16'h0001));
    chk("sml line_cnt l3", rl[43], 3);
    for (int l = 0; l < 4; l++) begin
      c = 16'hFFFF;
      for (int x = 0; x < 8; x++)
        c = m_crc(c, 8'(x + l + 1));
      chk($sformatf("sml l%0d pay0", l),
          r0[10 + 11 * l], l + 1);
      chk($sformatf("sml l%0d crc", l),
          {r1[14 + 11 * l], r0[14 + 11 * l]}, c);
    end

    // CSI-2 CRC example payload via override
    pulse(2);
    capture(2, 30, 0, 0);
    chk("crc ex pay0", {r0[9], r1[9]}, 16'hFF00);
    chk("crc ex pay1", {r0[10], r1[10]}, 16'h0002);
    chk("crc ex lane0", r0[21], 8'hF0);
    chk("crc ex lane1", r1[21], 8'h00);
    c = 16'hFFFF;
    for (int x = 0; x < 24; x++) begin
      t = OVR >> (8 * x);
      c = m_crc(c, t[7:0]);
    end
    chk("crc ex model", {r1[21], r0[21]}, c);
    chk("crc busy cycles", busy_cnt(30), 28);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
